// File: rtl/uart_pkg.sv
// Shared constants for the oversampling UART receiver: parity modes and FSM state encoding.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRKWAIT
  } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, re-phased by a synchronous restart.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clock,
  input  logic nrst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (restart || cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CW'(DIV - 1)) && !restart;

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 2-FF synchroniser, 3-sample majority voter, frame FSM and
// valid/ready output stage with parity, framing and overrun reporting.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | line idle, waiting for rx_s 1->0
//  ST_START   | checking start bit at mid-bit; a 1 vote is a false start
//  ST_DATA    | shifting DATA_BITS voted bits, LSB first
//  ST_PARITY  | voting parity bit and recording mismatch
//  ST_STOP    | voting stop bit(s); word delivered at mid of the last one
//  ST_BRKWAIT | line still low after the frame (break); wait for rx_s=1
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int OVS_DIV   = 27,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 nrst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS + 1);

  rx_state_t state, state_nx;

  logic rx_m, rx_s, rx_d;
  logic tick, start_edge, mid, bit_end;
  logic s0, s1, vote;
  logic last_data, last_stop, deliver;
  logic par_bad, fe_acc;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic          stop_cnt;
  logic [DATA_BITS-1:0] shreg;

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign start_edge = (state == ST_IDLE) && rx_d && !rx_s;

  uart_baud_tick #(.DIV(OVS_DIV)) u_tick (
    .clock   (clock),
    .nrst    (nrst),
    .restart (start_edge),
    .tick    (tick)
  );

  // Third sample comes straight from rx_s so the vote is ready on the mid tick itself.
  assign vote      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign mid       = tick && (tick_cnt == TW'(OVS / 2 + 1));
  assign bit_end   = tick && (tick_cnt == TW'(OVS - 1));
  assign last_data = (bit_cnt == BW'(DATA_BITS - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
  assign deliver   = (state == ST_STOP) && mid && last_stop;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (start_edge) state_nx = ST_START;
      ST_START: begin
        if (mid && vote)  state_nx = ST_IDLE;
        else if (bit_end) state_nx = ST_DATA;
      end
      ST_DATA:    if (bit_end && last_data)
                    state_nx = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY:  if (bit_end) state_nx = ST_STOP;
      ST_STOP:    if (deliver) state_nx = rx_s ? ST_IDLE : ST_BRKWAIT;
      ST_BRKWAIT: if (rx_s) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      s0       <= 1'b0;
      s1       <= 1'b0;
      shreg    <= '0;
      par_bad  <= 1'b0;
      fe_acc   <= 1'b0;
    end else if (start_edge) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bad  <= 1'b0;
      fe_acc   <= 1'b0;
    end else if (tick) begin
      tick_cnt <= (tick_cnt == TW'(OVS - 1)) ? '0 : tick_cnt + 1'b1;
      if (tick_cnt == TW'(OVS / 2 - 1)) s0 <= rx_s;
      if (tick_cnt == TW'(OVS / 2))     s1 <= rx_s;
      if (mid) begin
        case (state)
          ST_DATA:   shreg   <= {vote, shreg[DATA_BITS-1:1]};
          ST_PARITY: par_bad <= vote ^ (^shreg) ^ (PARITY == PARITY_ODD);
          ST_STOP:   if (!vote) fe_acc <= 1'b1;
          default:   ;
        endcase
      end
      if (bit_end && state == ST_DATA) bit_cnt  <= last_data ? '0 : bit_cnt + 1'b1;
      if (bit_end && state == ST_STOP) stop_cnt <= stop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (deliver) begin
      if (!rx_valid || rx_ready) begin
        rx_data    <= shreg;
        parity_err <= (PARITY != PARITY_NONE) && par_bad;
        frame_err  <= fe_acc | ~vote;
        rx_valid   <= 1'b1;
        overrun    <= 1'b0;
      end else begin
        overrun    <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: an 8N1 instance and an even-parity instance driven
// with hand-built serial frames at 27*16 clocks per bit.
module tb_uart_rx_ovs;

  localparam int BIT = 27 * 16;

  logic       clock, nrst;
  logic       rx, rx_ready, rx_valid, parity_err, frame_err, overrun, busy;
  logic [7:0] rx_data;
  logic       rx_p, p_ready, p_valid, p_parity_err, p_frame_err, p_overrun, p_busy;
  logic [7:0] p_data;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc;
  bit seen;

  uart_rx_ovs #(.OVS_DIV(27), .OVS(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut (
    .clock(clock), .nrst(nrst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  uart_rx_ovs #(.OVS_DIV(27), .OVS(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_par (
    .clock(clock), .nrst(nrst), .rx(rx_p), .rx_data(p_data), .rx_valid(p_valid),
    .rx_ready(p_ready), .parity_err(p_parity_err), .frame_err(p_frame_err),
    .overrun(p_overrun), .busy(p_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #950000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_bit(input bit sel, input logic v);
    if (sel) rx_p = v;
    else     rx   = v;
    repeat (BIT) @(posedge clock);
  endtask

  // par < 0 means no parity bit on the wire
  task automatic send_frame(input bit sel, input logic [7:0] d, input int par);
    put_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) put_bit(sel, d[i]);
    if (par >= 0) put_bit(sel, par[0]);
    put_bit(sel, 1'b1);
  endtask

  task automatic wait_valid(input bit sel, input int max, output int n);
    n = 0;
    while (!(sel ? p_valid : rx_valid) && n < max) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic accept(input bit sel);
    @(negedge clock);
    if (sel) p_ready = 1'b1;
    else     rx_ready = 1'b1;
    @(posedge clock); #1;
    if (sel) p_ready = 1'b0;
    else     rx_ready = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; rx = 1'b1; rx_p = 1'b1; rx_ready = 1'b0; p_ready = 1'b0;
    repeat (3) @(posedge clock); #1;
    check("rst_valid",   rx_valid, 0);
    check("rst_data",    rx_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy",    busy, 0);
    @(negedge clock); nrst = 1'b1;
    repeat (BIT) @(posedge clock); #1;

    // 8N1 0xA5 with start-to-valid latency around 9.5 bit periods
    fork
      send_frame(1'b0, 8'hA5, -1);
      wait_valid(1'b0, 5000, cyc);
    join
    check("a5_latency_window", (cyc >= BIT * 19 / 2 - BIT / 4) && (cyc <= BIT * 19 / 2 + BIT / 4), 1);
    check("a5_data",       rx_data, 8'hA5);
    check("a5_parity_err", parity_err, 0);
    check("a5_frame_err",  frame_err, 0);
    check("a5_overrun",    overrun, 0);
    accept(1'b0);
    check("a5_accept_valid", rx_valid, 0);

    // start glitch of 4 ticks
    rx = 1'b0;
    repeat (50) @(posedge clock); #1;
    check("glitch_busy", busy, 1);
    repeat (4 * 27 - 50) @(posedge clock);
    rx = 1'b1;
    seen = 1'b0;
    repeat (2 * BIT) begin @(posedge clock); #1; if (rx_valid) seen = 1'b1; end
    check("glitch_no_valid", seen, 0);
    check("glitch_idle", busy, 0);

    // overrun with rx_ready held low
    send_frame(1'b0, 8'h11, -1);
    check("ovr_first_valid", rx_valid, 1);
    check("ovr_first_data",  rx_data, 8'h11);
    put_bit(1'b0, 1'b1);
    send_frame(1'b0, 8'h22, -1);
    check("ovr_held_data",  rx_data, 8'h11);
    check("ovr_flag",       overrun, 1);
    check("ovr_held_valid", rx_valid, 1);
    accept(1'b0);
    check("ovr_clear_flag",  overrun, 0);
    check("ovr_clear_valid", rx_valid, 0);

    // line break for two frame times
    rx = 1'b0;
    wait_valid(1'b0, 5000, cyc);
    check("brk_valid",     cyc < 5000, 1);
    check("brk_data",      rx_data, 8'h00);
    check("brk_frame_err", frame_err, 1);
    check("brk_busy",      busy, 1);
    accept(1'b0);
    seen = 1'b0;
    repeat (20 * BIT - cyc - 2) begin @(posedge clock); #1; if (rx_valid) seen = 1'b1; end
    check("brk_no_repeat", seen, 0);
    rx = 1'b1;
    repeat (2 * BIT) @(posedge clock); #1;
    check("brk_release_idle", busy, 0);
    send_frame(1'b0, 8'h3C, -1);
    check("post_brk_valid", rx_valid, 1);
    check("post_brk_data",  rx_data, 8'h3C);
    check("post_brk_fe",    frame_err, 0);

    // reset pulse mid-DATA while 0x3C is still held
    fork
      send_frame(1'b0, 8'hFF, -1);
      begin
        repeat (4 * BIT) @(posedge clock);
        #2 nrst = 1'b0;
        #1;
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data",  rx_data, 0);
        check("mid_rst_busy",  busy, 0);
        check("mid_rst_fe",    frame_err, 0);
        @(posedge clock); #1 nrst = 1'b1;
      end
    join
    repeat (BIT) @(posedge clock); #1;
    check("mid_rst_discard", rx_valid, 0);
    send_frame(1'b0, 8'h5A, -1);
    check("after_rst_valid", rx_valid, 1);
    check("after_rst_data",  rx_data, 8'h5A);
    check("after_rst_fe",    frame_err, 0);
    accept(1'b0);

    // even parity: 0x03 has XOR 0, so a parity bit of 1 is a mismatch
    send_frame(1'b1, 8'h03, 1);
    check("par_bad_valid", p_valid, 1);
    check("par_bad_data",  p_data, 8'h03);
    check("par_bad_flag",  p_parity_err, 1);
    check("par_bad_fe",    p_frame_err, 0);
    accept(1'b1);
    check("par_accept_overrun", p_overrun, 0);
    send_frame(1'b1, 8'h03, 0);
    check("par_ok_valid", p_valid, 1);
    check("par_ok_flag",  p_parity_err, 0);
    repeat (BIT) @(posedge clock); #1;
    check("par_idle", p_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
